// File: rtl/qkv_line_pingpong_buf.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// qkv_line_pingpong_buf
//
// Ping-pong line buffer between the Q/K/V spike reshaper and the systolic-array
// feeder. Incoming spike lines (one per strobe, no backpressure) are collected
// DEPTH at a time into one of two banks. Each full bank is streamed to the
// feeder REPLAY times over a valid/ready handshake and then released. Filling
// of one bank overlaps readout of the other.
//
// Ports:
//   s_clk               clock
//   s_rst_n             asynchronous active-low reset
//   i_spikesLine_in     spike line from the reshaper (LINE_W bits)
//   i_spikesLine_valid  single-cycle line strobe
//   i_flush             synchronous clear (beats everything else)
//   o_line_data         line to the feeder
//   o_line_popcnt       number of ones in o_line_data (optional, see below)
//   o_line_valid        o_line_data valid
//   i_line_ready        feeder accepts the current line
//   o_line_last         current line is the final entry of this pass
//   o_pass_idx          current pass index
//   o_tile_done         one-cycle pulse when a bank is released
//   o_bank_full         per-bank full flags
//   o_overflow          sticky: a line arrived with no free slot and was dropped
//
// Build option:
//   QKV_LINE_POPCNT_EN  when defined, adds o_line_popcnt, registered together
//                       with o_line_data.
// ---------------------------------------------------------------------------
module qkv_line_pingpong_buf #(
  parameter int LINE_W = 128,
  parameter int DEPTH  = 16,
  parameter int REPLAY = 4
) (
  input  logic                      s_clk,
  input  logic                      s_rst_n,
  input  logic [LINE_W-1:0]         i_spikesLine_in,
  input  logic                      i_spikesLine_valid,
  input  logic                      i_flush,
  output logic [LINE_W-1:0]         o_line_data,
`ifdef QKV_LINE_POPCNT_EN
  output logic [$clog2(LINE_W):0]   o_line_popcnt,
`endif
  output logic                      o_line_valid,
  input  logic                      i_line_ready,
  output logic                      o_line_last,
  output logic [$clog2(REPLAY):0]   o_pass_idx,
  output logic                      o_tile_done,
  output logic [1:0]                o_bank_full,
  output logic                      o_overflow
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int PASS_W = $clog2(REPLAY) + 1;
  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(REPLAY - 1);

  typedef enum logic {IDLE, READ} state_t;

  state_t             state;
  logic [LINE_W-1:0]  mem [2][DEPTH];
  logic               wr_bank;
  logic               rd_bank;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PASS_W-1:0]  pass;
  logic [1:0]         bank_full;

  logic               xfer;
  logic               final_xfer;
  logic               start;
  logic               load;
  logic               wr_room;
  logic               wr_en;
  logic               wr_drop;
  logic [PTR_W-1:0]   rd_addr;
  logic [LINE_W-1:0]  rd_word;

`ifdef QKV_LINE_POPCNT_EN
  localparam int CNT_W = $clog2(LINE_W) + 1;

  function automatic logic [CNT_W-1:0] popcount(input logic [LINE_W-1:0] v);
    logic [CNT_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < LINE_W; i++) begin
      acc = acc + CNT_W'(v[i]);
    end
    return acc;
  endfunction
`endif

  // NOTE: every signal below is assigned on every path through the block, so
  // no latch can be inferred; keep it that way when adding terms.
  always_comb begin
    xfer       = (state == READ) && o_line_valid && i_line_ready;
    final_xfer = xfer && (rd_ptr == LAST_PTR) && (pass == LAST_PASS);
    start      = (state == IDLE) && bank_full[rd_bank];
    // Next entry is fetched on the same edge as the handshake, so a steadily
    // ready feeder sees one line per cycle with no bubbles.
    load       = start || (xfer && !final_xfer);
    rd_addr    = (start || (rd_ptr == LAST_PTR)) ? '0 : rd_ptr + PTR_W'(1);
    rd_word    = mem[rd_bank][rd_addr];
    // A bank being released this cycle can already take its first new line.
    wr_room    = !bank_full[wr_bank] || (final_xfer && (rd_bank == wr_bank));
    wr_en      = i_spikesLine_valid && wr_room && !i_flush;
    wr_drop    = i_spikesLine_valid && !wr_room;
  end

  // NOTE: line storage carries no reset; its contents are only read after a
  // bank has been completely rewritten, so clearing it would buy nothing.
  always_ff @(posedge s_clk) begin
    if (wr_en) begin
      mem[wr_bank][wr_ptr] <= i_spikesLine_in;
    end
  end

  // NOTE: all state updates use non-blocking assignments so every branch sees
  // the pre-edge values regardless of statement order.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state        <= IDLE;
      wr_bank      <= 1'b0;
      rd_bank      <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      pass         <= '0;
      bank_full    <= 2'b00;
      o_line_data  <= '0;
`ifdef QKV_LINE_POPCNT_EN
      o_line_popcnt <= '0;
`endif
      o_line_valid <= 1'b0;
      o_tile_done  <= 1'b0;
      o_overflow   <= 1'b0;
    end else if (i_flush) begin
      // Flush discards both banks and any readout in flight; no release pulse.
      state        <= IDLE;
      wr_bank      <= 1'b0;
      rd_bank      <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      pass         <= '0;
      bank_full    <= 2'b00;
      o_line_valid <= 1'b0;
      o_tile_done  <= 1'b0;
      o_overflow   <= 1'b0;
    end else begin
      o_tile_done <= 1'b0;

      if (load) begin
        o_line_data <= rd_word;
`ifdef QKV_LINE_POPCNT_EN
        o_line_popcnt <= popcount(rd_word);
`endif
        rd_ptr      <= rd_addr;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state        <= READ;
            o_line_valid <= 1'b1;
            pass         <= '0;
          end
        end
        READ: begin
          if (final_xfer) begin
            bank_full[rd_bank] <= 1'b0;
            rd_bank            <= ~rd_bank;
            pass               <= '0;
            o_line_valid       <= 1'b0;
            o_tile_done        <= 1'b1;
            state              <= IDLE;
          end else if (xfer && (rd_ptr == LAST_PTR)) begin
            pass <= pass + PASS_W'(1);
          end
        end
        default: state <= IDLE;
      endcase

      // Write side comes after the release so that a set on the same bank
      // would win; with DEPTH >= 2 the two never coincide on one bank.
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        if (wr_ptr == LAST_PTR) begin
          bank_full[wr_bank] <= 1'b1;
          wr_bank            <= ~wr_bank;
        end
      end

      if (wr_drop) begin
        o_overflow <= 1'b1;
      end
    end
  end

  assign o_line_last = o_line_valid && (rd_ptr == LAST_PTR);
  assign o_pass_idx  = pass;
  assign o_bank_full = bank_full;

endmodule
